// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer after the last SDF stage: writes each frame at
// bit-reversed addresses and streams it back out in natural order.
module fft_bitrev_reorder #(
  parameter int N     = 128,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic             do_first,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
);

  localparam int LOG_N = $clog2(N);
  localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);
  localparam logic [LOG_N-1:0] ONE  = LOG_N'(1);

  typedef enum logic {IDLE, RUN} state_t;

  logic [2*WIDTH-1:0] mem_q [2*N];

  state_t           state_q;
  logic [LOG_N-1:0] wr_cnt_q;
  logic [LOG_N-1:0] rd_cnt_q;
  logic             wr_bank_q;
  logic             rd_bank_q;
  logic [1:0]       full_q;
  logic             en_q;
  logic             first_q;
  logic [WIDTH-1:0] re_q;
  logic [WIDTH-1:0] im_q;

  logic             wr_done;
  logic             rd_done;
  logic             other_full;
  logic [1:0]       full_d;
  logic [2*WIDTH-1:0] rd_data;

  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
    logic [LOG_N-1:0] r;
    for (int i = 0; i < LOG_N; i++) r[i] = a[LOG_N-1-i];
    return r;
  endfunction

  always_comb begin
    wr_done = di_en && (wr_cnt_q == LAST);
    rd_done = (state_q == RUN) && (rd_cnt_q == LAST);
    full_d  = full_q;
    if (rd_done) full_d[rd_bank_q] = 1'b0;
    if (wr_done) full_d[wr_bank_q] = 1'b1;
    // includes a fill completing on this very edge, for seamless handoff
    other_full = full_d[~rd_bank_q];
    rd_data    = mem_q[{rd_bank_q, rd_cnt_q}];
  end

  always_ff @(posedge clk) begin
    if (di_en && !rst) begin
      mem_q[{wr_bank_q, bitrev(wr_cnt_q)}] <= {di_re, di_im};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      en_q      <= 1'b0;
      first_q   <= 1'b0;
      re_q      <= '0;
      im_q      <= '0;
    end else begin
      if (di_en) begin
        wr_cnt_q <= wr_cnt_q + ONE;
        if (wr_done) wr_bank_q <= ~wr_bank_q;
      end
      full_q  <= full_d;
      en_q    <= (state_q == RUN);
      first_q <= (state_q == RUN) && (rd_cnt_q == '0);
      unique case (state_q)
        IDLE: begin
          if (full_q[rd_bank_q]) begin
            state_q  <= RUN;
            rd_cnt_q <= '0;
          end
        end
        RUN: begin
          re_q     <= rd_data[2*WIDTH-1:WIDTH];
          im_q     <= rd_data[WIDTH-1:0];
          rd_cnt_q <= rd_cnt_q + ONE;
          if (rd_done) begin
            rd_bank_q <= ~rd_bank_q;
            if (!other_full) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign do_en    = en_q;
  assign do_first = first_q;
  assign do_re    = re_q;
  assign do_im    = im_q;

endmodule
